// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and gate-length constants for the frequency meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CLK_FREQ_HZ       = 50_000_000;
  localparam int GATE_CYCLES_1S    = CLK_FREQ_HZ;
  localparam int GATE_CYCLES_100MS = CLK_FREQ_HZ / 10;
  localparam int GATE_CYCLES_10MS  = CLK_FREQ_HZ / 100;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// rtl/freq_meter_sync_edge_detect.sv - 2-FF synchronizer with a one-cycle rising-edge pulse
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts sig_in rising edges over a fixed gate window and publishes the count
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_1S,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic sig_level;
  logic sig_rise;
  logic count_en;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .level    (sig_level),
    .rise     (sig_rise)
  );

  assign count_en = sig_rise & sig_level;

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_count_q, freq_count_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] edge_next;
  logic             sat_next;

  always_comb begin
    edge_next = edge_cnt_q;
    sat_next  = sat_q;
    if (count_en) begin
      if (edge_cnt_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt_q + CNT_W'(1);
      end
    end

    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    freq_count_d = freq_count_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (start || continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      GATE: begin
        edge_cnt_d = edge_next;
        sat_d      = sat_next;
        gate_cnt_d = gate_cnt_q + GW'(1);
        // The last gate cycle's edge is folded into the published result.
        if (gate_cnt_q == GATE_LAST) begin
          state_d      = DONE;
          freq_count_d = edge_next;
          overflow_d   = sat_next;
        end
      end
      DONE: begin
        if (continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      sat_q        <= 1'b0;
      freq_count_q <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      sat_q        <= sat_d;
      freq_count_q <= freq_count_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign freq_count = freq_count_q;
  assign overflow   = overflow_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter with a 100-cycle gate
module tb_freq_meter;

  logic        clk;
  logic        reset;
  logic        sig_in;
  logic        start;
  logic        continuous;
  logic [25:0] freq_count;
  logic        valid;
  logic        overflow;
  logic        busy;
  logic        start_s;
  logic [3:0]  freq_count_s;
  logic        valid_s;
  logic        overflow_s;
  logic        busy_s;

  typedef struct {
    int     cnt;
    bit     ovf;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   exp_s_q[$];
  exp_t   e_m;
  exp_t   e_s;
  longint cyc;
  int     checks;
  int     errors;
  int     half;
  bit     sig_const;
  int     busy_cnt;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(26)) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .freq_count (freq_count),
    .valid      (valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_s (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start_s),
    .continuous (1'b0),
    .freq_count (freq_count_s),
    .valid      (valid_s),
    .overflow   (overflow_s),
    .busy       (busy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // sig_in: half==0 holds sig_const, otherwise toggles every half cycles
  initial begin
    int ph;
    ph     = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (half == 0) begin
        sig_in = sig_const;
        ph     = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          ph     = 0;
          sig_in = ~sig_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e_m = exp_q.pop_front();
        chk("count", freq_count, e_m.cnt);
        chk("overflow", overflow, e_m.ovf);
        chk("valid_cycle", cyc, e_m.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_s) begin
      if (exp_s_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_s actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e_s = exp_s_q.pop_front();
        chk("count_s", freq_count_s, e_s.cnt);
        chk("overflow_s", overflow_s, e_s.ovf);
        chk("valid_cycle_s", cyc, e_s.cyc);
      end
    end
  end

  task automatic start_single(input int c);
    @(negedge clk);
    exp_q.push_back('{cnt: c, ovf: 1'b0, cyc: cyc + 101});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_period(input int p, input bit lvl);
    half      = p / 2;
    sig_const = lvl;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    half       = 0;
    sig_const  = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    start_s    = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_freq_count", freq_count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy_s", busy_s, 0);
    reset = 1'b0;

    // single shot, period 10, busy width
    set_period(10, 1'b0);
    @(negedge clk);
    exp_q.push_back('{cnt: 10, ovf: 1'b0, cyc: cyc + 101});
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    repeat (114) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 101);

    set_period(2, 1'b0);
    start_single(50);
    repeat (115) @(negedge clk);

    set_period(0, 1'b0);
    start_single(0);
    repeat (115) @(negedge clk);

    set_period(0, 1'b1);
    start_single(0);
    repeat (115) @(negedge clk);

    // continuous, then drop continuous during the third gate
    set_period(20, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{cnt: 5, ovf: 1'b0, cyc: cyc + 101 + 101 * i});
    continuous = 1'b1;
    repeat (250) @(negedge clk);
    continuous = 1'b0;
    repeat (60) @(negedge clk);
    chk("cont_busy_after", busy, 0);
    chk("cont_pending", exp_q.size(), 0);

    // asynchronous reset at gate cycle 50
    set_period(10, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_freq_count", freq_count, 0);
    chk("arst_valid", valid, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    start_single(10);
    repeat (115) @(negedge clk);

    // start pulse while busy is ignored
    start_single(10);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (120) @(negedge clk);
    chk("busy_start_pending", exp_q.size(), 0);

    // 4-bit counter saturates, then recovers
    set_period(4, 1'b0);
    @(negedge clk);
    exp_s_q.push_back('{cnt: 15, ovf: 1'b1, cyc: cyc + 101});
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (115) @(negedge clk);
    set_period(0, 1'b0);
    @(negedge clk);
    exp_s_q.push_back('{cnt: 0, ovf: 1'b0, cyc: cyc + 101});
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (115) @(negedge clk);

    chk("final_pending", exp_q.size(), 0);
    chk("final_pending_s", exp_s_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external, asynchronous square-wave input against the 50 MHz board clock.
- Counts rising edges of `sig_in` over a fixed gate window, then latches the count and pulses `valid`.
- With the default 1 s gate, the result is the input frequency in Hz.
- Used to check divided clocks (1/10/100 Hz outputs) on the board and to drive 7-segment readouts.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in clk cycles (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, width of the edge count and of `freq_count` (covers up to 25 MHz).

Ports:
- clk  input  1  50 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  single-shot request, sampled only in IDLE.
- continuous  input  1  1 = re-arm automatically after each result.
- freq_count  output  CNT_W  rising edges counted in the last completed gate; saturating.
- valid  output  1  one-cycle pulse when `freq_count` is updated.
- overflow  output  1  set if the last completed gate's count saturated.
- busy  output  1  high in GATE and DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - Returns to IDLE immediately, including mid-gate; no partial result is published.
  - freq_count=0, valid=0, overflow=0, busy=0.
  - Synchronizer flops, gate counter and edge counter all cleared.
- Input path:
  - `sig_in` passes through a 2-FF synchronizer, then a third flop for edge detection.
  - `rise` = sync & ~prev, asserted for exactly one cycle per rising edge.
  - Input-to-`rise` latency is 2-3 clk.
  - Maximum measurable input frequency is clk/2.
- States IDLE, GATE, DONE (enum in package).
- IDLE:
  - Moves to GATE on the edge where `start` or `continuous` is 1.
  - Entering GATE clears gate_cnt and edge_cnt.
- GATE:
  - Lasts exactly GATE_CYCLES cycles, with gate_cnt running 0..GATE_CYCLES-1.
  - Every cycle with `rise`=1 increments edge_cnt.
  - edge_cnt saturates at 2^CNT_W-1 and sets a sticky internal sat flag.
  - On the last cycle (gate_cnt==GATE_CYCLES-1), that cycle's `rise` is included.
  - At that edge: freq_count <= final count, overflow <= sat, valid <= 1, state <= DONE.
- DONE:
  - Lasts exactly 1 cycle; `valid` is high only during it.
  - Next state is GATE if `continuous`=1 (counters cleared), otherwise IDLE.
  - `rise` during DONE is not counted (one dead cycle per measurement).
- Timing: in continuous mode a result arrives every GATE_CYCLES+1 cycles. For single-shot, with start seen at edge T, valid is high in cycle T+GATE_CYCLES+1.
- `start`:
  - Ignored while busy.
  - A held-high `start` is treated as level: the block re-measures each time it returns to IDLE.
- `freq_count` and `overflow` hold their values between results; they are updated only at the GATE->DONE edge.
- Clearing `continuous` mid-gate completes the current gate, then goes to IDLE.

Decomposition:
- freq_meter_pkg holds:
  - `state_t` enum {IDLE, GATE, DONE};
  - CLK_FREQ_HZ = 50_000_000;
  - default GATE_CYCLES constants for 1 s / 100 ms / 10 ms gates.
- Sub-module `sync_edge_detect`: 2-FF synchronizer plus rising-edge pulse (clk, reset, async_in -> level, rise). It is reusable for push-buttons.
- freq_meter contains the FSM, gate counter and saturating edge counter.

Test Plan:
- GATE_CYCLES=100; sig_in period 10 clk (5 high/5 low) running before start; start pulse -> one valid pulse 101 cycles after start edge, freq_count=10, overflow=0, busy high during those 101 cycles.
- GATE_CYCLES=100; sig_in toggling every clk (period 2) -> freq_count=50; sig_in held 0, then held 1 -> freq_count=0 in both cases.
- GATE_CYCLES=100, CNT_W=4; sig_in period 4 (25 edges) -> freq_count=15, overflow=1; next gate with constant input -> freq_count=0, overflow=0.
- GATE_CYCLES=100; continuous=1, sig_in period 20 -> valid pulses exactly 101 cycles apart, each freq_count=5; drop continuous mid-gate -> one more result, then busy=0.
- GATE_CYCLES=100; reset asserted at gate cycle 50 (asynchronous, between clk edges) -> outputs 0 immediately, no valid pulse; after release, start -> normal result 10 for period-10 input.
- start pulsed again while busy (gate cycle 30) -> ignored: exactly one valid pulse, with timing unchanged.
